fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the write side of the dual-clock FIFO among NUM_REQ valid-ready requesters in the write clock domain. Grants are packet-locked: a granted requester keeps the port until it sends a beat with `last`, or until a beat cap is reached. The block drives one registered output stage whose valid/ready/data connect to the FIFO write port; the source ID and `last` travel alongside so downstream logic can pack them into the FIFO word.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: payload width per requester.
- ID_WIDTH, 2: source ID width, must equal ceil(log2(NUM_REQ)).
- MAX_BEATS, 16: beat cap per grant; 0 means no cap (release on `last` only).

Ports:
- i_clk  in  1  clock (FIFO write clock domain).
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  NUM_REQ  per-requester valid.
- o_ready  out  NUM_REQ  per-requester ready.
- i_data  in  NUM_REQ*DATA_WIDTH  payloads, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_last  in  NUM_REQ  per-requester end-of-packet flag.
- o_valid  out  1  output beat valid (registered).
- i_ready  in  1  downstream (FIFO writer) ready.
- o_data  out  DATA_WIDTH  output payload (registered).
- o_id  out  ID_WIDTH  source index of the o_data beat (registered).
- o_last  out  1  i_last of that beat (registered).
- o_grant  out  NUM_REQ  one-hot current grant; all zero in IDLE.

## Operation
- Two states:
  - IDLE: all o_ready = 0.
  - LOCK: only the granted requester can be ready.
- IDLE: if any i_valid is set, pick the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ. Load the grant register and beat_cnt = 0, then go to LOCK. With no i_valid set, stay in IDLE.
- LOCK:
  - Ready: o_ready[g] = !o_valid || i_ready; the other o_ready bits are 0.
  - Accept: a beat is accepted when i_valid[g] && o_ready[g]. The output register then loads i_data[g], g, i_last[g], and o_valid becomes 1.
  - Drain: if there is no accept and i_ready = 1, o_valid goes to 0.
  - Release: on an accepted beat with i_last[g] = 1, or with MAX_BEATS != 0 and beat_cnt == MAX_BEATS-1, go to IDLE. Set rr_ptr = (g+1) mod NUM_REQ and clear o_grant.
  - Otherwise beat_cnt increments on each accepted beat.
- beat_cnt width: ceil(log2(MAX_BEATS+1)) bits, minimum 1. It never wraps, because release occurs at MAX_BEATS-1.
- A cap release does not modify o_last. The next grant to the same requester continues its packet.
- If the granted requester drops i_valid mid-packet, the grant is held and no other requester is served.
- The output register holds o_data, o_id and o_last stable while o_valid && !i_ready.
- Reset, including mid-packet:
  - State = IDLE, rr_ptr = 0, beat_cnt = 0.
  - All outputs = 0: o_valid, o_data, o_id, o_last, o_grant, o_ready.
  - Any beat held in the output register is discarded.

## Timing
- Arbitration costs 1 cycle: the request is seen in IDLE at cycle n, and o_ready[g] rises at cycle n+1.
- Latency from accept to output is 1 cycle: a beat accepted at edge t is on o_data after edge t.
- Throughput: 1 beat per cycle within a grant while i_ready = 1. Each grant costs 1 idle cycle at release.
- Back-to-back accepts are allowed when i_ready = 1 and the output register is full; the ready equation passes the data through.
- o_ready depends combinationally on i_ready and state only, never on i_valid.

## Structure
- Shared package: state encoding constants (ST_IDLE = 0, ST_LOCK = 1) and a clog2 function used for ID_WIDTH and beat_cnt width checks.
- Sub-module fifo_rr_pick: combinational rotating-priority picker.
  - Inputs: req[NUM_REQ], ptr[ID_WIDTH].
  - Outputs: any, idx[ID_WIDTH], onehot[NUM_REQ].
- Top level holds the FSM, grant/rr_ptr/beat_cnt registers and the output register.
- Parameter check: an elaboration error is raised if ID_WIDTH < clog2(NUM_REQ).

## Test plan
- Reset mid-packet (req 1 locked, o_valid = 1, i_rst pulsed) -> all outputs 0 on the next sample, and the next grant goes to req 0 (rr_ptr = 0).
- Fairness: all four requesters hold valid continuously, each sending 2-beat packets with `last` on beat 2, i_ready = 1 -> o_id sequence 0,0,1,1,2,2,3,3,0,0. There is one output bubble after each packet.
- Cap: req 2 sends a 20-beat packet with `last` only on beat 20, MAX_BEATS = 16, req 3 idle -> 16 beats with o_id = 2 and o_last = 0, then a release. Req 2 is regranted and sends 4 beats, o_last = 1 on the 20th.
- Backpressure: req 0 sends data 0xA5, 0x5A, 0x3C while i_ready = 0 for 3 cycles after the first beat -> o_data holds 0xA5 and o_ready[0] = 0 throughout. The beats then emerge in order with no loss or duplication.
- Wrap and skip: rr_ptr = 3 and only req 1 is valid -> req 1 is granted and rr_ptr becomes 2 after its `last`.
- Gap mid-packet: req 0 is granted, drops i_valid for 5 cycles mid-packet, and req 1 is valid -> o_grant stays 4'b0001 and req 1 gets no o_ready until req 0's `last` beat.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter shared definitions.
// State encoding and elaboration-time width helper.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter requester and FIFO write port bundle.
// slave = arbiter side, master = requesters/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);

  logic [NUM_REQ-1:0]            i_valid;
  logic [NUM_REQ-1:0]            o_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]            i_last;
  logic                          o_valid;
  logic                          i_ready;
  logic [DATA_WIDTH-1:0]         o_data;
  logic [ID_WIDTH-1:0]           o_id;
  logic                          o_last;
  logic [NUM_REQ-1:0]            o_grant;

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_last,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data,
    output o_id,
    output o_last,
    output o_grant
  );

  modport master (
    output i_valid,
    output i_data,
    output i_last,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_id,
    input  o_last,
    input  o_grant
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit at or
// above ptr, wrapping modulo NUM_REQ.
module fifo_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx,
  output logic [NUM_REQ-1:0]  onehot
);

  int k;

  // Scan upward from ptr and keep the first hit.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    k      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = ID_WIDTH'(k);
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding the FIFO
// write port through one registered output stage.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_BEATS  = 16
) (
  input logic         i_clk,
  input logic         i_rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int CW_RAW = clog2(MAX_BEATS + 1);
  localparam int CW = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int CAP_I =
    (MAX_BEATS == 0) ? 0 : MAX_BEATS - 1;
  localparam logic [CW-1:0] CAP = CW'(CAP_I);
  localparam logic [ID_WIDTH-1:0] LAST_IDX =
    ID_WIDTH'(NUM_REQ - 1);

  if (ID_WIDTH < clog2(NUM_REQ)) begin : g_chk
    $error("ID_WIDTH too small for NUM_REQ");
  end

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [ID_WIDTH-1:0]   gidx_q, gidx_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  last_q, last_d;

  logic                  pick_any;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [NUM_REQ-1:0]    pick_oh;
  logic                  out_free;
  logic                  accept;
  logic                  cap_hit;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_pick (
    .req   (bus.i_valid),
    .ptr   (rr_ptr_q),
    .any   (pick_any),
    .idx   (pick_idx),
    .onehot(pick_oh)
  );

  // Ready/accept terms; ready never looks at i_valid.
  always_comb begin
    out_free = !valid_q || bus.i_ready;
    bus.o_ready = '0;
    if (state_q == ST_LOCK)
      bus.o_ready = grant_q & {NUM_REQ{out_free}};
    accept = (state_q == ST_LOCK) &&
             bus.i_valid[gidx_q] && out_free;
    g_last = bus.i_last[gidx_q];
    g_data =
      bus.i_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    cap_hit = (MAX_BEATS != 0) && (beat_cnt_q == CAP);
  end

  // Next-state, grant bookkeeping and output stage.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    valid_d    = valid_q;
    data_d     = data_q;
    id_d       = id_q;
    last_d     = last_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = g_data;
      id_d    = gidx_q;
      last_d  = g_last;
    end else if (bus.i_ready) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_LOCK;
          grant_d    = pick_oh;
          gidx_d     = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (accept) begin
          if (g_last || cap_hit) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            rr_ptr_d = (gidx_q == LAST_IDX) ?
                       '0 : gidx_q + ID_WIDTH'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any held beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      id_q       <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      id_q       <= id_d;
      last_q     <= last_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_id    = id_q;
  assign bus.o_last  = last_q;
  assign bus.o_grant = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter.
// Per-requester beat queues; expected output order queued.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .MAX_BEATS(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  beat_t      rq[N][$];
  exp_t       sb[$];
  logic [N-1:0] gap;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input int k, input logic [7:0] d,
                     input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    rq[k].push_back(b);
  endtask

  task automatic expb(input int id, input logic [7:0] d,
                      input logic l);
    exp_t e;
    e.id = IW'(id);
    e.d  = d;
    e.l  = l;
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0 && !gap[k]) begin
        bus.i_valid[k] = 1'b1;
        bus.i_data[k*DW +: DW] = rq[k][0].d;
        bus.i_last[k] = rq[k][0].l;
      end else begin
        bus.i_valid[k] = 1'b0;
        bus.i_data[k*DW +: DW] = '0;
        bus.i_last[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] fire;
    logic         ofire;
    exp_t         got;
    exp_t         e;
    #1;
    fire  = bus.i_valid & bus.o_ready;
    ofire = bus.o_valid && bus.i_ready;
    got   = {bus.o_id, bus.o_data, bus.o_last};
    @(posedge clk);
    #1;
    if (ofire) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("beat", 32'(got), 32'(e));
      end
    end
    for (int k = 0; k < N; k++)
      if (fire[k] && rq[k].size() > 0)
        void'(rq[k].pop_front());
    drive();
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || bus.o_valid;
    for (int k = 0; k < N; k++)
      if (rq[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string tag, output int n);
    n = 0;
    while (busy() && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_bound"}, 32'(n < 300), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  int n;
  int idle;

  initial begin
    rst = 1'b1;
    gap = '0;
    bus.i_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_grant", 32'(bus.o_grant), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(bus.o_ready), 32'd0);

    // fairness: 0,0,1,1,2,2,3,3,0,0
    add(0, 8'h00, 1'b0); add(0, 8'h01, 1'b1);
    add(0, 8'h02, 1'b0); add(0, 8'h03, 1'b1);
    for (int k = 1; k < N; k++) begin
      add(k, 8'(k*16), 1'b0);
      add(k, 8'(k*16+1), 1'b1);
    end
    expb(0, 8'h00, 1'b0); expb(0, 8'h01, 1'b1);
    for (int k = 1; k < N; k++) begin
      expb(k, 8'(k*16), 1'b0);
      expb(k, 8'(k*16+1), 1'b1);
    end
    expb(0, 8'h02, 1'b0); expb(0, 8'h03, 1'b1);
    drive();
    drain("fair", n);
    chk("fair_cycles", 32'(n), 32'd16);

    // reset mid-packet while req 1 is locked
    bus.i_ready = 1'b0;
    add(1, 8'h40, 1'b0); add(1, 8'h41, 1'b0);
    add(1, 8'h42, 1'b1);
    drive();
    n = 0;
    while (!bus.o_valid && n < 10) begin
      step();
      n++;
    end
    chk("mid_locked", 32'(bus.o_grant), 32'h2);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(bus.o_valid), 32'd0);
    chk("mr_data", 32'(bus.o_data), 32'd0);
    chk("mr_id", 32'(bus.o_id), 32'd0);
    chk("mr_last", 32'(bus.o_last), 32'd0);
    chk("mr_grant", 32'(bus.o_grant), 32'd0);
    chk("mr_ready", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) rq[k].delete();
    bus.i_ready = 1'b1;
    add(0, 8'h50, 1'b1); add(1, 8'h60, 1'b1);
    expb(0, 8'h50, 1'b1); expb(1, 8'h60, 1'b1);
    drive();
    drain("post_rst", n);

    // beat cap: 20-beat packet from req 2
    for (int b = 0; b < 20; b++) begin
      add(2, 8'(b), b == 19);
      expb(2, 8'(b), b == 19);
    end
    drive();
    idle = 0;
    n = 0;
    while (busy() && n < 200) begin
      if (bus.o_grant == '0 && rq[2].size() > 0) idle++;
      step();
      n++;
    end
    chk("cap_idle", 32'(idle), 32'd2);
    chk("cap_sb", 32'(sb.size()), 32'd0);

    // backpressure on req 0
    add(0, 8'hA5, 1'b0); add(0, 8'h5A, 1'b0);
    add(0, 8'h3C, 1'b1);
    expb(0, 8'hA5, 1'b0); expb(0, 8'h5A, 1'b0);
    expb(0, 8'h3C, 1'b1);
    drive();
    n = 0;
    while (!bus.o_valid && n < 10) begin
      step();
      n++;
    end
    chk("bp_first", 32'(bus.o_valid), 32'd1);
    bus.i_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_data", 32'(bus.o_data), 32'hA5);
      chk("bp_ready0", 32'(bus.o_ready[0]), 32'd0);
      step();
    end
    bus.i_ready = 1'b1;
    drain("bp", n);

    // wrap and skip: move rr_ptr to 3, then only req 1
    add(2, 8'h70, 1'b1); expb(2, 8'h70, 1'b1);
    drive();
    drain("wrap_a", n);
    add(1, 8'h80, 1'b1); expb(1, 8'h80, 1'b1);
    drive();
    step();
    chk("wrap_grant", 32'(bus.o_grant), 32'h2);
    drain("wrap_b", n);
    add(0, 8'h90, 1'b1); add(2, 8'hA0, 1'b1);
    add(3, 8'hB0, 1'b1);
    expb(2, 8'hA0, 1'b1); expb(3, 8'hB0, 1'b1);
    expb(0, 8'h90, 1'b1);
    drive();
    drain("wrap_c", n);

    // gap mid-packet on req 0 with req 1 waiting
    add(0, 8'hC0, 1'b0); add(0, 8'hC1, 1'b0);
    add(0, 8'hC2, 1'b1);
    expb(0, 8'hC0, 1'b0); expb(0, 8'hC1, 1'b0);
    expb(0, 8'hC2, 1'b1);
    drive();
    n = 0;
    while (rq[0].size() == 3 && n < 10) begin
      step();
      n++;
    end
    gap[0] = 1'b1;
    add(1, 8'hD0, 1'b1); expb(1, 8'hD0, 1'b1);
    drive();
    repeat (5) begin
      #1;
      chk("gap_grant", 32'(bus.o_grant), 32'h1);
      chk("gap_ready1", 32'(bus.o_ready[1]), 32'd0);
      step();
    end
    gap[0] = 1'b0;
    drive();
    drain("gap", n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
